// File: rtl/byte_mask_decoder.sv
// byte_mask_decoder: registered byte-lane mask generator for the cache data path.
// Converts (byte offset, log2 size) into a contiguous byte-enable mask over
// BLOCK_BYTES = 2**OFFSET_W lanes. Accesses that cross the block end are emitted
// as two beats: the head in the current block, then the tail in the next block.
// Optional feature macro: BYTE_MASK_ALIGN_CHECK_EN. When it is defined, misaligned
// requests produce a single error beat instead of a mask.
module byte_mask_decoder #(
  parameter int OFFSET_W = 4,
  parameter int SIZE_W   = 3
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [OFFSET_W-1:0]      req_offset,
  input  logic [SIZE_W-1:0]        req_size,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2**OFFSET_W-1:0]   out_mask,
  output logic                     out_second,
  output logic                     out_last,
  output logic                     out_err
);

  localparam int                BLOCK_BYTES = 2**OFFSET_W;
  localparam logic [OFFSET_W:0] BLOCK_END   = (OFFSET_W+1)'(BLOCK_BYTES);

  typedef enum logic {
    IDLE,
    SPLIT
  } state_t;

  state_t                   state;
  logic [OFFSET_W-1:0]      tail_len;   // byte count of the pending tail beat

  logic [OFFSET_W:0]        span;
  logic [OFFSET_W:0]        end_pos;
  logic                     crosses;
  logic                     misaligned;
  logic                     accept;
  logic [BLOCK_BYTES-1:0]   head_mask;
  logic [BLOCK_BYTES-1:0]   tail_mask;

  // A new request is taken only in IDLE, and only when the output register is
  // free or being drained this cycle.
  assign req_ready = reset_n && (state == IDLE) && (!out_valid || out_ready);
  assign accept    = req_valid && req_ready;

  // Span, end position and the head/tail lane masks for the current request.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    span      = BLOCK_END;
    head_mask = '0;
    tail_mask = '0;
    if (int'(req_size) < OFFSET_W) begin
      span = (OFFSET_W+1)'(1) << req_size;
    end
    end_pos = {1'b0, req_offset} + span;
    // The top bit of end_pos is set once the access reaches the block end. The
    // access crosses only if it goes past the end, and the low bits then give
    // the tail length directly.
    crosses = end_pos[OFFSET_W] && (|end_pos[OFFSET_W-1:0]);
    for (int i = 0; i < BLOCK_BYTES; i++) begin
      head_mask[i] = ((OFFSET_W+1)'(i) >= {1'b0, req_offset}) &&
                     ((OFFSET_W+1)'(i) < end_pos);
      tail_mask[i] = (OFFSET_W)'(i) < tail_len;
    end
  end

`ifdef BYTE_MASK_ALIGN_CHECK_EN
  logic [OFFSET_W-1:0] span_low_m1;

  // Aligned means the offset is a multiple of span. For a full-block span the low
  // bits wrap to all ones, so only offset 0 is accepted as aligned.
  assign span_low_m1 = span[OFFSET_W-1:0] - (OFFSET_W)'(1);
  assign misaligned  = |(req_offset & span_low_m1);
`else
  assign misaligned  = 1'b0;
`endif

  // Control FSM with registered beat outputs and synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples values from before the edge and simulation matches hardware.
    if (!reset_n) begin
      state      <= IDLE;
      tail_len   <= '0;
      out_valid  <= 1'b0;
      out_mask   <= '0;
      out_second <= 1'b0;
      out_last   <= 1'b0;
      out_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            out_valid  <= 1'b1;
            out_second <= 1'b0;
            if (misaligned) begin
              out_mask <= '0;
              out_last <= 1'b1;
              out_err  <= 1'b1;
            end else if (crosses) begin
              out_mask <= head_mask;
              out_last <= 1'b0;
              out_err  <= 1'b0;
              tail_len <= end_pos[OFFSET_W-1:0];
              state    <= SPLIT;
            end else begin
              out_mask <= head_mask;
              out_last <= 1'b1;
              out_err  <= 1'b0;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        SPLIT: begin
          // The head beat is showing. Once it is taken, load the tail beat.
          if (out_ready) begin
            out_mask   <= tail_mask;
            out_second <= 1'b1;
            out_last   <= 1'b1;
            out_err    <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_byte_mask_decoder.sv
// tb_byte_mask_decoder: directed self-checking bench for byte_mask_decoder with
// default parameters (16 byte lanes). Expected values are hand-computed. When
// BYTE_MASK_ALIGN_CHECK_EN is defined, the misaligned cases expect error beats.
module tb_byte_mask_decoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_offset;
  logic [2:0]  req_size;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_mask;
  logic        out_second;
  logic        out_last;
  logic        out_err;

  int checks = 0;
  int errors = 0;

  byte_mask_decoder #(.OFFSET_W(4), .SIZE_W(3)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_offset (req_offset),
    .req_size   (req_size),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_mask   (out_mask),
    .out_second (out_second),
    .out_last   (out_last),
    .out_err    (out_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Compare the full beat currently on the outputs.
  task automatic expect_beat(input string tag, input logic [15:0] mask,
                             input logic second, input logic last, input logic err);
    check({tag, ".valid"},  out_valid,  1'b1);
    check({tag, ".mask"},   out_mask,   mask);
    check({tag, ".second"}, out_second, second);
    check({tag, ".last"},   out_last,   last);
    check({tag, ".err"},    out_err,    err);
  endtask

  // Present one request, wait a bounded time for acceptance, then take one edge.
  task automatic send(input string tag, input logic [3:0] off, input logic [2:0] sz);
    int waited;
    waited     = 0;
    req_offset = off;
    req_size   = sz;
    req_valid  = 1'b1;
    while (!req_ready && waited < 20) begin
      tick();
      waited++;
    end
    check({tag, ".accept"}, req_ready, 1'b1);
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_offset = '0;
    req_size   = '0;
    out_ready  = 1'b1;
    tick();
    tick();
    check("reset.valid",  out_valid,  1'b0);
    check("reset.mask",   out_mask,   16'h0000);
    check("reset.second", out_second, 1'b0);
    check("reset.last",   out_last,   1'b0);
    check("reset.err",    out_err,    1'b0);
    check("reset.ready",  req_ready,  1'b0);
    reset_n = 1'b1;
    #1;
    check("idle.ready", req_ready, 1'b1);

    // 1: unsplit access
    send("t1", 4'd4, 3'd2);
    expect_beat("t1", 16'h00F0, 1'b0, 1'b1, 1'b0);
    tick();
    check("t1.drop", out_valid, 1'b0);

    // 2: crossing access, offset 14, 4 bytes
    send("t2", 4'd14, 3'd2);
`ifdef BYTE_MASK_ALIGN_CHECK_EN
    expect_beat("t2.err", 16'h0000, 1'b0, 1'b1, 1'b1);
`else
    expect_beat("t2.head", 16'hC000, 1'b0, 1'b0, 1'b0);
    check("t2.split_ready", req_ready, 1'b0);
    tick();
    expect_beat("t2.tail", 16'h0003, 1'b1, 1'b1, 1'b0);
    check("t2.tail_ready", req_ready, 1'b1);
`endif
    tick();
    check("t2.drop", out_valid, 1'b0);

    // 3: full-block span at offset 8, then an oversize request that is clamped
    send("t3a", 4'd8, 3'd4);
`ifdef BYTE_MASK_ALIGN_CHECK_EN
    expect_beat("t3a.err", 16'h0000, 1'b0, 1'b1, 1'b1);
`else
    expect_beat("t3a.head", 16'hFF00, 1'b0, 1'b0, 1'b0);
    tick();
    expect_beat("t3a.tail", 16'h00FF, 1'b1, 1'b1, 1'b0);
`endif
    tick();
    send("t3b", 4'd0, 3'd7);
    expect_beat("t3b", 16'hFFFF, 1'b0, 1'b1, 1'b0);
    tick();
    check("t3b.drop", out_valid, 1'b0);

    // 4: hold under backpressure, then back-to-back at one beat per cycle
    out_ready = 1'b0;
    send("t4a", 4'd2, 3'd1);
    req_offset = 4'd0;
    req_size   = 3'd0;
    req_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      expect_beat("t4.hold", 16'h000C, 1'b0, 1'b1, 1'b0);
      check("t4.hold_ready", req_ready, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("t4.release_ready", req_ready, 1'b1);
    tick();
    expect_beat("t4.b2b0", 16'h0001, 1'b0, 1'b1, 1'b0);
    req_offset = 4'd4;  req_size = 3'd2;
    tick();
    expect_beat("t4.b2b1", 16'h00F0, 1'b0, 1'b1, 1'b0);
    req_offset = 4'd8;  req_size = 3'd1;
    tick();
    expect_beat("t4.b2b2", 16'h0300, 1'b0, 1'b1, 1'b0);
    req_offset = 4'd15; req_size = 3'd0;
    tick();
    expect_beat("t4.b2b3", 16'h8000, 1'b0, 1'b1, 1'b0);
    req_valid = 1'b0;
    tick();
    check("t4.drop", out_valid, 1'b0);

    // 5: reset while the head beat is pending; the tail must never appear
    out_ready = 1'b0;
    send("t5", 4'd12, 3'd3);
`ifdef BYTE_MASK_ALIGN_CHECK_EN
    expect_beat("t5.err", 16'h0000, 1'b0, 1'b1, 1'b1);
`else
    expect_beat("t5.head", 16'hF000, 1'b0, 1'b0, 1'b0);
`endif
    reset_n = 1'b0;
    tick();
    check("t5.rst_valid", out_valid, 1'b0);
    check("t5.rst_mask",  out_mask,  16'h0000);
    check("t5.rst_ready", req_ready, 1'b0);
    reset_n   = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t5.no_tail", out_valid, 1'b0);
    end

    // 6: aligned request near the block end
    send("t6", 4'd12, 3'd2);
    expect_beat("t6", 16'hF000, 1'b0, 1'b1, 1'b0);
    tick();
    check("t6.drop", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
